// File: rtl/partition_sweep_pkg.sv
// Shared types, sizing constants and helper function for the partition sweep sequencer.
package partition_sweep_pkg;

  localparam int NUM_IN_DEF  = 7;
  localparam int NUM_OUT_DEF = 4;
  localparam int N_PAT       = 1 << NUM_IN_DEF;
  localparam int HD_W        = NUM_IN_DEF + $clog2(NUM_OUT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/partition_sweep_ctrl_popcount.sv
// Number of bit positions where the approximate and exact partition outputs differ.
module partition_popcount
  import partition_sweep_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic [CW-1:0] o_cnt
);

  logic [31:0] w_diff;
  logic [5:0]  w_pc;

  assign w_diff = 32'(i_a ^ i_b);
  assign w_pc   = popcount(w_diff);
  assign o_cnt  = CW'(w_pc);

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Sweeps every input pattern through a partition, emits one truth-table row per
// pattern on a valid/ready stream and accumulates mismatch / Hamming-distance totals.
module partition_sweep_ctrl
  import partition_sweep_pkg::*;
#(
  parameter int NUM_IN  = NUM_IN_DEF,
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int DUT_LAT = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  output logic [NUM_IN-1:0]                      pattern_o,
  input  logic [NUM_OUT-1:0]                     dut_po_i,
  input  logic [NUM_OUT-1:0]                     gold_po_i,
  output logic                                   row_valid,
  input  logic                                   row_ready,
  output logic [NUM_IN-1:0]                      row_idx,
  output logic [NUM_OUT-1:0]                     row_data,
  output logic                                   busy,
  output logic                                   done,
  output logic [NUM_IN:0]                        err_count,
  output logic [NUM_IN+$clog2(NUM_OUT+1)-1:0]    hd_sum
);

  localparam int CNT_W = $clog2(NUM_OUT + 1);
  localparam int SUM_W = NUM_IN + CNT_W;
  localparam int LAT_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

  sweep_state_t r_state, w_state_next;

  logic [NUM_IN-1:0]  r_pattern;
  logic [LAT_W-1:0]   r_settle_cnt;
  logic [NUM_IN-1:0]  r_row_idx;
  logic [NUM_OUT-1:0] r_row_data;
  logic [NUM_IN:0]    r_err_count;
  logic [SUM_W-1:0]   r_hd_sum;

  logic [CNT_W-1:0]   w_hd;
  logic               w_mismatch;
  logic               w_last_settle;
  logic               w_last_pattern;

  partition_popcount #(
    .W  (NUM_OUT),
    .CW (CNT_W)
  ) u_popcount (
    .i_a   (dut_po_i),
    .i_b   (gold_po_i),
    .o_cnt (w_hd)
  );

  assign w_mismatch     = (dut_po_i != gold_po_i);
  assign w_last_settle  = (r_settle_cnt == LAT_W'(DUT_LAT - 1));
  assign w_last_pattern = &r_pattern;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (start) w_state_next = SETTLE;
      SETTLE: begin
        if (abort)              w_state_next = IDLE;
        else if (w_last_settle) w_state_next = EMIT;
      end
      EMIT: begin
        if (abort)          w_state_next = IDLE;
        else if (row_ready) w_state_next = w_last_pattern ? DONE : SETTLE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Accumulation is tied to the final settle edge, so stalls in EMIT never recount.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern    <= '0;
      r_settle_cnt <= '0;
      r_row_idx    <= '0;
      r_row_data   <= '0;
      r_err_count  <= '0;
      r_hd_sum     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pattern    <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
            r_hd_sum     <= '0;
          end
        end
        SETTLE: begin
          if (!abort) begin
            if (w_last_settle) begin
              r_settle_cnt <= '0;
              r_row_idx    <= r_pattern;
              r_row_data   <= dut_po_i;
              r_err_count  <= r_err_count + (NUM_IN + 1)'(w_mismatch);
              r_hd_sum     <= r_hd_sum + SUM_W'(w_hd);
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (!abort && row_ready && !w_last_pattern) begin
            r_pattern <= r_pattern + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pattern_o = r_pattern;
  assign row_valid = (r_state == EMIT);
  assign row_idx   = r_row_idx;
  assign row_data  = r_row_data;
  assign busy      = (r_state == SETTLE) || (r_state == EMIT);
  assign done      = (r_state == DONE);
  assign err_count = r_err_count;
  assign hd_sum    = r_hd_sum;

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Self-checking bench for partition_sweep_ctrl: table of full sweeps with a row
// scoreboard, plus hand-written abort and mid-sweep reset sequences.
module tb_partition_sweep_ctrl;
  import partition_sweep_pkg::*;

  localparam int NI = 7;
  localparam int NO = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, row_ready;
  logic [NI-1:0] pattern_o, row_idx;
  logic [NO-1:0] dut_po_i, gold_po_i, row_data;
  logic          row_valid, busy, done;
  logic [NI:0]   err_count;
  logic [HD_W-1:0] hd_sum;

  int mode = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rows_seen = 0;
  int done_pulses = 0;

  typedef struct {
    logic [NI-1:0] idx;
    logic [NO-1:0] data;
  } row_t;
  row_t q[$];

  typedef struct {
    int mode;
    bit stall;
    int exp_err;
    int exp_hd;
    int exp_lat;
    bit start_on_done;
  } case_t;
  case_t cases[4];

  partition_sweep_ctrl #(.NUM_IN(NI), .NUM_OUT(NO), .DUT_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern_o(pattern_o), .dut_po_i(dut_po_i), .gold_po_i(gold_po_i),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
    .row_data(row_data), .busy(busy), .done(done),
    .err_count(err_count), .hd_sum(hd_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NO-1:0] dut_model(input logic [NI-1:0] p, input int m);
    logic [NO-1:0] g;
    g = p[NO-1:0];
    case (m)
      1:       return (p == 7'd5) ? (g ^ 4'b0101) : g;
      2:       return ~g;
      default: return g;
    endcase
  endfunction

  always_comb begin
    gold_po_i = pattern_o[NO-1:0];
    dut_po_i  = dut_model(pattern_o, mode);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Row scoreboard: compares every presented row, pops on an accepted transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_pulses++;
      if (row_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL row_unexpected: got idx %0d expected no row", row_idx);
        end else begin
          check("row_idx", 64'(row_idx), 64'(q[0].idx));
          check("row_data", 64'(row_data), 64'(q[0].data));
          if (row_ready && !abort) begin
            $display("row idx=%0d data=%h", row_idx, row_data);
            void'(q.pop_front());
            rows_seen++;
          end
        end
      end
    end
  end

  task automatic load_rows(input int m);
    q.delete();
    rows_seen = 0;
    for (int p = 0; p < N_PAT; p++) begin
      row_t r;
      r.idx  = NI'(p);
      r.data = dut_model(NI'(p), m);
      q.push_back(r);
    end
  endtask

  task automatic do_start(output int k);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_cleared", 64'(err_count), 64'd0);
  endtask

  task automatic run_sweep(input case_t t);
    int k, stall_left;
    bit got;
    mode = t.mode;
    load_rows(t.mode);
    do_start(k);
    stall_left = 3;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (t.stall && row_valid && row_idx == 7'd10 && stall_left > 0) begin
        row_ready = 1'b0;
        stall_left--;
      end else begin
        row_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    row_ready = 1'b1;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done");
    end
    check("done_latency", 64'(cyc - k), 64'(t.exp_lat));
    check("busy_in_done", 64'(busy), 64'd0);
    check("err_count", 64'(err_count), 64'(t.exp_err));
    check("hd_sum", 64'(hd_sum), 64'(t.exp_hd));
    check("rows_delivered", 64'(rows_seen), 64'(N_PAT));
    check("rows_pending", 64'(q.size()), 64'd0);
    $display("sweep mode=%0d stall=%0d err=%0d hd=%0d lat=%0d",
             t.mode, t.stall, err_count, hd_sum, cyc - k);
    if (t.start_on_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_with_done_ignored", 64'(busy), 64'd0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("err_hold", 64'(err_count), 64'(t.exp_err));
    check("hd_hold", 64'(hd_sum), 64'(t.exp_hd));
  endtask

  task automatic wait_row(input logic [NI-1:0] idx, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (row_valid && row_idx == idx) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no row expected row %0d", name, idx);
    end
  endtask

  initial begin
    int k, dp;
    bit got;
    cases[0] = '{mode: 0, stall: 1'b0, exp_err: 0,   exp_hd: 0,   exp_lat: 256, start_on_done: 1'b1};
    cases[1] = '{mode: 1, stall: 1'b0, exp_err: 1,   exp_hd: 2,   exp_lat: 256, start_on_done: 1'b0};
    cases[2] = '{mode: 2, stall: 1'b0, exp_err: 128, exp_hd: 512, exp_lat: 256, start_on_done: 1'b0};
    cases[3] = '{mode: 2, stall: 1'b1, exp_err: 128, exp_hd: 512, exp_lat: 259, start_on_done: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; row_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({pattern_o, row_valid, row_idx, row_data, busy, done, err_count, hd_sum}), 64'd0);
    rst = 1'b0;

    for (int c = 0; c < 4; c++) run_sweep(cases[c]);

    // Abort at row 40 with an ignored start at row 20.
    mode = 2;
    load_rows(2);
    do_start(k);
    wait_row(7'd20, "wait_row20");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_row(7'd40, "wait_row40");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    dp = done_pulses;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_row_valid", 64'(row_valid), 64'd0);
    check("abort_err_partial", 64'(err_count), 64'd41);
    check("abort_hd_partial", 64'(hd_sum), 64'd164);
    check("abort_rows_delivered", 64'(rows_seen), 64'd40);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_pulses), 64'(dp));
    check("abort_stays_idle", 64'(busy), 64'd0);
    $display("abort err=%0d hd=%0d rows=%0d", err_count, hd_sum, rows_seen);
    q.delete();

    // Reset in the middle of a sweep, then a fresh full sweep.
    mode = 0;
    load_rows(0);
    do_start(k);
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (pattern_o == 7'd64) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reach_pattern64", 64'(got), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midsweep_reset_outputs",
          64'({pattern_o, row_valid, row_idx, row_data, busy, done, err_count, hd_sum}), 64'd0);
    $display("reset mid-sweep at pattern 64");
    q.delete();
    run_sweep(cases[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
